// File: rtl/mem_request_ctrl.sv
// Request controller between the pipeline datapath and the I/D caches: registered fetch
// enable, one held data transaction, halt sequencing, watchdog. Define MEM_REQ_PERF_EN for stall_cnt.
module mem_request_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TMO_W  = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              halt,
    input  logic              iREN_in,
    input  logic              dREN_in,
    input  logic              dWEN_in,
    input  logic [ADDR_W-1:0] iaddr_in,
    input  logic [ADDR_W-1:0] daddr_in,
    input  logic [DATA_W-1:0] store_in,
    input  logic              ihit_in,
    input  logic              dhit_in,
    output logic              iREN_out,
    output logic              dREN_out,
    output logic              dWEN_out,
    output logic [ADDR_W-1:0] iaddr_out,
    output logic [ADDR_W-1:0] daddr_out,
    output logic [DATA_W-1:0] store_out,
    output logic              ihit_out,
    output logic              dhit_out,
    output logic              busy,
    output logic              halted,
    output logic              timeout_err
`ifdef MEM_REQ_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_HALT = 2'd2
    } state_e;

    localparam logic [TMO_W-1:0] TMO_MAX = '1;

    state_e              state_q, state_d;
    logic                iren_q, iren_d;
    logic                dren_q, dren_d;
    logic                dwen_q, dwen_d;
    logic [ADDR_W-1:0]   daddr_q, daddr_d;
    logic [DATA_W-1:0]   store_q, store_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                tmo_err_q, tmo_err_d;

    // NOTE: every _d signal takes its _q value first, so no path through this block leaves a latch.
    always_comb begin
        state_d   = state_q;
        dren_d    = dren_q;
        dwen_d    = dwen_q;
        daddr_d   = daddr_q;
        store_d   = store_q;
        tmo_cnt_d = tmo_cnt_q;
        tmo_err_d = tmo_err_q;
        iren_d    = iREN_in & ~halt & (state_q != S_HALT);

        unique case (state_q)
            S_IDLE: begin
                if (halt) begin
                    state_d = S_HALT;
                end else if (ihit_in && (dREN_in || dWEN_in)) begin
                    state_d   = S_DATA;
                    daddr_d   = daddr_in;
                    store_d   = store_in;
                    dwen_d    = dWEN_in;
                    dren_d    = dREN_in & ~dWEN_in;
                    tmo_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (dhit_in) begin
                    // A pending halt is honoured only once the transaction has retired.
                    dren_d  = 1'b0;
                    dwen_d  = 1'b0;
                    state_d = halt ? S_HALT : S_IDLE;
                end else begin
                    if (tmo_cnt_q != TMO_MAX) begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                    if (tmo_cnt_d == TMO_MAX) begin
                        tmo_err_d = 1'b1;
                    end
                end
            end
            S_HALT: begin
                dren_d = 1'b0;
                dwen_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                dren_d  = 1'b0;
                dwen_d  = 1'b0;
            end
        endcase
    end

    // NOTE: state flops use non-blocking assignments and an asynchronous active-low reset branch.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= S_IDLE;
            iren_q    <= 1'b0;
            dren_q    <= 1'b0;
            dwen_q    <= 1'b0;
            daddr_q   <= '0;
            store_q   <= '0;
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            iren_q    <= iren_d;
            dren_q    <= dren_d;
            dwen_q    <= dwen_d;
            daddr_q   <= daddr_d;
            store_q   <= store_d;
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

`ifdef MEM_REQ_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == S_DATA) && !dhit_in && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

    assign iREN_out    = iren_q;
    assign dREN_out    = dren_q;
    assign dWEN_out    = dwen_q;
    assign daddr_out   = daddr_q;
    assign store_out   = store_q;
    assign iaddr_out   = iaddr_in;
    assign ihit_out    = ihit_in;
    assign dhit_out    = dhit_in & (state_q == S_DATA);
    assign busy        = (state_q == S_DATA);
    assign halted      = (state_q == S_HALT);
    assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_mem_request_ctrl.sv
// Scoreboard bench for mem_request_ctrl (TMO_W=4): accepted transactions are queued by the
// stimulus and compared by a monitor when busy rises; directed checks cover the rest.
module tb_mem_request_ctrl;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TMO_W  = 4;
    localparam int CNT_W  = 32;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              ren;
        logic              wen;
    } txn_t;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              halt, iREN_in, dREN_in, dWEN_in, ihit_in, dhit_in;
    logic [ADDR_W-1:0] iaddr_in, daddr_in;
    logic [DATA_W-1:0] store_in;
    logic              iREN_out, dREN_out, dWEN_out, ihit_out, dhit_out;
    logic              busy, halted, timeout_err;
    logic [ADDR_W-1:0] iaddr_out, daddr_out;
    logic [DATA_W-1:0] store_out;
`ifdef MEM_REQ_PERF_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  stall_base;
`endif

    int   total = 0;
    int   bad   = 0;
    txn_t exp_q[$];
    logic busy_prev = 1'b0;

    mem_request_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TMO_W(TMO_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .n_rst(n_rst), .halt(halt),
        .iREN_in(iREN_in), .dREN_in(dREN_in), .dWEN_in(dWEN_in),
        .iaddr_in(iaddr_in), .daddr_in(daddr_in), .store_in(store_in),
        .ihit_in(ihit_in), .dhit_in(dhit_in),
        .iREN_out(iREN_out), .dREN_out(dREN_out), .dWEN_out(dWEN_out),
        .iaddr_out(iaddr_out), .daddr_out(daddr_out), .store_out(store_out),
        .ihit_out(ihit_out), .dhit_out(dhit_out),
        .busy(busy), .halted(halted), .timeout_err(timeout_err)
`ifdef MEM_REQ_PERF_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a new transaction is presented whenever busy rises.
    always @(negedge clk) begin
        if (n_rst && busy && !busy_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_txn", 64'(busy), 64'd0);
            end else begin
                txn_t t;
                t = exp_q.pop_front();
                check("mon_daddr", 64'(daddr_out), 64'(t.addr));
                check("mon_store", 64'(store_out), 64'(t.data));
                check("mon_dren",  64'(dREN_out),  64'(t.ren));
                check("mon_dwen",  64'(dWEN_out),  64'(t.wen));
            end
        end
        busy_prev = busy;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input logic ren, input logic wen);
        txn_t t;
        t.addr = a; t.data = d; t.ren = ren & ~wen; t.wen = wen;
        exp_q.push_back(t);
        ihit_in = 1'b1; dREN_in = ren; dWEN_in = wen; daddr_in = a; store_in = d;
        tick(1);
        ihit_in = 1'b0; dREN_in = 1'b0; dWEN_in = 1'b0;
    endtask

    task automatic retire(input string name);
        dhit_in = 1'b1;
        #1 check({name, "_dhit_out"}, 64'(dhit_out), 64'd1);
        tick(1);
        dhit_in = 1'b0;
        #1 check({name, "_dhit_out_low"}, 64'(dhit_out), 64'd0);
        check({name, "_dren_clr"}, 64'(dREN_out), 64'd0);
        check({name, "_dwen_clr"}, 64'(dWEN_out), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        n_rst = 1'b0; halt = 1'b0; iREN_in = 1'b0; dREN_in = 1'b0; dWEN_in = 1'b0;
        ihit_in = 1'b0; dhit_in = 1'b0; iaddr_in = '0; daddr_in = '0; store_in = '0;
        #12;
        check("rst_dren", 64'(dREN_out), 64'd0);
        check("rst_dwen", 64'(dWEN_out), 64'd0);
        check("rst_iren", 64'(iREN_out), 64'd0);
        check("rst_daddr", 64'(daddr_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_tmo", 64'(timeout_err), 64'd0);
`ifdef MEM_REQ_PERF_EN
        check("rst_stall", 64'(stall_cnt), 64'd0);
`endif
        n_rst = 1'b1;
        tick(1);

        // Fetch enable pass-throughs and one-cycle registered latency.
        iREN_in = 1'b1; iaddr_in = 32'h0000_1000; ihit_in = 1'b1;
        #1 check("iaddr_pass", 64'(iaddr_out), 64'h1000);
        check("ihit_pass", 64'(ihit_out), 64'd1);
        check("iren_latency", 64'(iREN_out), 64'd0);
        ihit_in = 1'b0;
        tick(1);
        check("iren_set", 64'(iREN_out), 64'd1);
        iREN_in = 1'b0;
        tick(1);
        check("iren_clr", 64'(iREN_out), 64'd0);

        // Load: 3 wait cycles then dhit.
        issue(32'h0000_0040, 32'h0, 1'b1, 1'b0);
        check("load_dren", 64'(dREN_out), 64'd1);
        check("load_daddr", 64'(daddr_out), 64'h40);
        tick(3);
        check("load_hold", 64'(dREN_out), 64'd1);
        retire("load");
        check("load_idle", 64'(busy), 64'd0);

        // Store with both enables: write wins; inputs changed during DATA are ignored.
        issue(32'h0000_0080, 32'hDEAD_BEEF, 1'b1, 1'b1);
        check("store_dwen", 64'(dWEN_out), 64'd1);
        check("store_dren", 64'(dREN_out), 64'd0);
        check("store_data", 64'(store_out), 64'hDEAD_BEEF);
        daddr_in = 32'h0000_1234; store_in = 32'h0;
        ihit_in = 1'b1; dREN_in = 1'b1;
        tick(2);
        check("store_addr_hold", 64'(daddr_out), 64'h80);
        check("store_data_hold", 64'(store_out), 64'hDEAD_BEEF);
        check("store_dwen_hold", 64'(dWEN_out), 64'd1);
        // ihit and dhit together: retire only, the pending request is not taken.
        retire("store");
        ihit_in = 1'b0; dREN_in = 1'b0;
        check("ihit_dhit_no_new", 64'(busy), 64'd0);
        check("idle_addr_kept", 64'(daddr_out), 64'h80);

        // Spurious dhit in IDLE.
        dhit_in = 1'b1;
        #1 check("spurious_dhit_out", 64'(dhit_out), 64'd0);
        tick(1);
        dhit_in = 1'b0;
        check("spurious_busy", 64'(busy), 64'd0);

`ifdef MEM_REQ_PERF_EN
        stall_base = stall_cnt;
        issue(32'h0000_0100, 32'h0, 1'b1, 1'b0);
        tick(3);
        retire("perf_a");
        issue(32'h0000_0104, 32'h1111_2222, 1'b0, 1'b1);
        tick(5);
        retire("perf_b");
        check("perf_stall_delta", 64'(stall_cnt - stall_base), 64'd8);
`endif

        // Watchdog fires after 15 DATA cycles without dhit (TMO_W=4).
        issue(32'h0000_0180, 32'h0, 1'b1, 1'b0);
        tick(14);
        check("tmo_not_yet", 64'(timeout_err), 64'd0);
        tick(1);
        check("tmo_fired", 64'(timeout_err), 64'd1);
        check("tmo_dren_held", 64'(dREN_out), 64'd1);
        tick(3);
        retire("tmo");
        check("tmo_sticky", 64'(timeout_err), 64'd1);
        check("tmo_idle", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of a transaction.
        iREN_in = 1'b1;
        issue(32'h0000_0200, 32'hCAFE_F00D, 1'b0, 1'b1);
        tick(1);
        check("pre_rst_busy", 64'(busy), 64'd1);
        n_rst = 1'b0;
        #1;
        check("arst_dwen", 64'(dWEN_out), 64'd0);
        check("arst_iren", 64'(iREN_out), 64'd0);
        check("arst_daddr", 64'(daddr_out), 64'd0);
        check("arst_store", 64'(store_out), 64'd0);
        check("arst_tmo", 64'(timeout_err), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        #1 n_rst = 1'b1;
        iREN_in = 1'b0;
        tick(1);

        // Halt raised in DATA waits for dhit, then HALT is absorbing.
        issue(32'h0000_0300, 32'h0, 1'b1, 1'b0);
        tick(1);
        halt = 1'b1;
        tick(2);
        check("halt_wait_busy", 64'(busy), 64'd1);
        check("halt_wait_dren", 64'(dREN_out), 64'd1);
        retire("halt");
        check("halted_set", 64'(halted), 64'd1);
        iREN_in = 1'b1;
        tick(3);
        check("halted_iren", 64'(iREN_out), 64'd0);
        halt = 1'b0;
        tick(2);
        check("halted_absorb", 64'(halted), 64'd1);
        check("halted_iren_low", 64'(iREN_out), 64'd0);
        iREN_in = 1'b0;

        // Halt wins over a simultaneous request from IDLE.
        n_rst = 1'b0;
        #2 n_rst = 1'b1;
        tick(1);
        halt = 1'b1; ihit_in = 1'b1; dREN_in = 1'b1; daddr_in = 32'h0000_0400;
        tick(1);
        halt = 1'b0; ihit_in = 1'b0; dREN_in = 1'b0;
        check("prio_halted", 64'(halted), 64'd1);
        check("prio_no_dren", 64'(dREN_out), 64'd0);
        check("prio_no_busy", 64'(busy), 64'd0);

        tick(2);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
